// File: rtl/fetch_parcel_stage_pkg.sv
// fetch_parcel_stage_pkg
//   Shared types for the parcel-granular fetch stage: parcel width, parcel and
//   parcel-entry types, the stage state encoding and a small min helper.
package fetch_parcel_stage_pkg;

  localparam int unsigned PARCEL_WIDTH = 16;

  typedef logic [PARCEL_WIDTH-1:0] parcel_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        fault;
    parcel_t     parcel;
  } fetch_parcel_entry_t;

  // Single-bit encoding kept identical to the legacy IDLE=0 / EMIT=1 values.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } fetch_state_e;

  function automatic int unsigned umin(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fetch_parcel_select.sv
// fetch_parcel_select
//   Combinational parcel shifter: returns WRITE_WIDTH consecutive 16-bit parcels
//   of an I-cache line starting at parcel offset off. Slots that fall past the
//   end of the line are zero.
// Ports
//   line     in   LINE_WIDTH                 held I-cache line
//   off      in   $clog2(PARCELS)+1          starting parcel offset (0..PARCELS)
//   parcels  out  WRITE_WIDTH*PARCEL_WIDTH   slot k = parcel off+k, slot 0 in [15:0]
module fetch_parcel_select
  import fetch_parcel_stage_pkg::*;
#(
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned WRITE_WIDTH = 4
) (
  input  logic [LINE_WIDTH-1:0]                      line,
  input  logic [$clog2(LINE_WIDTH/PARCEL_WIDTH):0]   off,
  output logic [WRITE_WIDTH*PARCEL_WIDTH-1:0]        parcels
);

  localparam int unsigned PARCELS = LINE_WIDTH / PARCEL_WIDTH;
  localparam int unsigned LOG     = $clog2(PARCELS);
  localparam int unsigned OFFW    = LOG + 1;

  parcel_t         line_p [PARCELS];
  logic [OFFW-1:0] idx;

  for (genvar p = 0; p < PARCELS; p++) begin : g_split
    assign line_p[p] = line[p*PARCEL_WIDTH +: PARCEL_WIDTH];
  end

  // PARCELS is a power of two and off+k < 2*PARCELS, so the top bit of idx
  // alone says whether the slot lies past the end of the line.
  always_comb begin
    parcels = '0;
    idx     = '0;
    for (int unsigned k = 0; k < WRITE_WIDTH; k++) begin
      idx = off + OFFW'(k);
      if (!idx[OFFW-1]) begin
        parcels[k*PARCEL_WIDTH +: PARCEL_WIDTH] = line_p[idx[LOG-1:0]];
      end
    end
  end

endmodule

// File: rtl/fetch_parcel_stage.sv
// fetch_parcel_stage
//   Registers one I-cache line per accepted fetch response and streams it into
//   the insn buffer as 16-bit parcels, from the PC's parcel offset to the end of
//   the line, up to WRITE_WIDTH parcels per cycle limited by buf_free. The line
//   is held until drained, so partial acceptance loses nothing.
//   Optional macro FETCH_PARCEL_PERF_EN enables saturating perf counters;
//   without it perf_stall/perf_parcel are tied to 0.
// Ports
//   clk, rst      clock; rst is asynchronous, active-low
//   flush         drop held line and pending output (top priority)
//   stall         pipeline fetch stall (no writes)
//   in_valid/in_ready, in_pc, in_line, in_fault   fetch response handshake
//   buf_free      free insn-buffer entries this cycle
//   wr_count, wr_pc, wr_parcel, wr_fault          insn-buffer write port
//   perf_stall    EMIT cycles with nothing written (macro only)
//   perf_parcel   total parcels written (macro only)
module fetch_parcel_stage
  import fetch_parcel_stage_pkg::*;
#(
  parameter int unsigned LINE_WIDTH  = 128,
  parameter int unsigned WRITE_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned FREE_WIDTH  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                stall,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ADDR_WIDTH-1:0]               in_pc,
  input  logic [LINE_WIDTH-1:0]               in_line,
  input  logic                                in_fault,
  input  logic [FREE_WIDTH-1:0]               buf_free,
  output logic [$clog2(WRITE_WIDTH):0]        wr_count,
  output logic [ADDR_WIDTH-1:0]               wr_pc,
  output logic [WRITE_WIDTH*PARCEL_WIDTH-1:0] wr_parcel,
  output logic                                wr_fault,
  output logic [31:0]                         perf_stall,
  output logic [31:0]                         perf_parcel
);

  localparam int unsigned PARCELS = LINE_WIDTH / PARCEL_WIDTH;
  localparam int unsigned LOG     = $clog2(PARCELS);
  localparam int unsigned OFFW    = LOG + 1;
  localparam int unsigned CNTW    = $clog2(WRITE_WIDTH) + 1;

  fetch_state_e                       state_q;
  logic [OFFW-1:0]                    off_q;
  logic [ADDR_WIDTH-1:0]              pc_q;
  logic [LINE_WIDTH-1:0]              line_q;
  logic                               fault_q;

  logic [CNTW-1:0]                    n;
  logic                               done;
  logic                               accept;
  logic [WRITE_WIDTH*PARCEL_WIDTH-1:0] sel;

  fetch_parcel_select #(
    .LINE_WIDTH (LINE_WIDTH),
    .WRITE_WIDTH(WRITE_WIDTH)
  ) u_select (
    .line   (line_q),
    .off    (off_q),
    .parcels(sel)
  );

  // Parcels written this cycle.
  always_comb begin
    n = '0;
    if (state_q == ST_EMIT && !flush && !stall) begin
      if (fault_q) begin
        n = (buf_free != '0) ? CNTW'(1) : '0;
      end else begin
        n = CNTW'(umin(umin(PARCELS - 32'(off_q), WRITE_WIDTH), 32'(buf_free)));
      end
    end
  end

  always_comb begin
    done     = (state_q == ST_EMIT) &&
               (((32'(off_q) + 32'(n)) == PARCELS) || (fault_q && n == CNTW'(1)));
    in_ready = rst && !flush && (state_q == ST_IDLE || done);
    accept   = in_valid && in_ready;
  end

  always_comb begin
    wr_count  = n;
    wr_pc     = pc_q;
    wr_fault  = fault_q && (n != '0);
    wr_parcel = '0;
    for (int unsigned k = 0; k < WRITE_WIDTH; k++) begin
      if ((k < 32'(n)) && !fault_q) begin
        wr_parcel[k*PARCEL_WIDTH +: PARCEL_WIDTH] = sel[k*PARCEL_WIDTH +: PARCEL_WIDTH];
      end
    end
  end

  // A new line can load either from IDLE or in the cycle the held line
  // finishes, so accept is checked before the drain/advance branch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      off_q   <= '0;
      pc_q    <= '0;
      line_q  <= '0;
      fault_q <= 1'b0;
    end else if (flush) begin
      state_q <= ST_IDLE;
    end else if (accept) begin
      state_q <= ST_EMIT;
      off_q   <= OFFW'(in_pc[LOG:1]);
      pc_q    <= in_pc & ~ADDR_WIDTH'(1);
      line_q  <= in_line;
      fault_q <= in_fault;
    end else if (state_q == ST_EMIT) begin
      if (done) begin
        state_q <= ST_IDLE;
      end else begin
        off_q <= off_q + OFFW'(n);
        pc_q  <= pc_q + (ADDR_WIDTH'(n) << 1);
      end
    end
  end

`ifdef FETCH_PARCEL_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_parcel_q;
  logic [32:0] parcel_sum;

  assign parcel_sum = {1'b0, perf_parcel_q} + 33'(n);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q  <= '0;
      perf_parcel_q <= '0;
    end else begin
      if (state_q == ST_EMIT && n == '0 && !flush && perf_stall_q != '1) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      perf_parcel_q <= parcel_sum[32] ? '1 : parcel_sum[31:0];
    end
  end

  assign perf_stall  = perf_stall_q;
  assign perf_parcel = perf_parcel_q;
`else
  assign perf_stall  = '0;
  assign perf_parcel = '0;
`endif

endmodule

// File: tb/tb_fetch_parcel_stage.sv
// tb_fetch_parcel_stage
//   Self-checking bench for fetch_parcel_stage (LINE_WIDTH=128, WRITE_WIDTH=4).
//   Expected writes are produced by a small line-slicing model into a queue
//   when a response is driven and popped as the stage writes.
module tb_fetch_parcel_stage;

  localparam int unsigned LW = 128;
  localparam int unsigned WW = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned FW = 4;
`ifdef FETCH_PARCEL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          stall = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_pc = '0;
  logic [LW-1:0] in_line = '0;
  logic          in_fault = 1'b0;
  logic [FW-1:0] buf_free = '0;
  logic [2:0]    wr_count;
  logic [AW-1:0] wr_pc;
  logic [63:0]   wr_parcel;
  logic          wr_fault;
  logic [31:0]   perf_stall;
  logic [31:0]   perf_parcel;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_pp = '0;

  typedef struct {
    logic [2:0]  cnt;
    logic [31:0] pc;
    logic [63:0] par;
    logic        fault;
    logic        last;
  } exp_t;

  exp_t q[$];

  fetch_parcel_stage #(
    .LINE_WIDTH (LW),
    .WRITE_WIDTH(WW),
    .ADDR_WIDTH (AW),
    .FREE_WIDTH (FW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .stall      (stall),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_line    (in_line),
    .in_fault   (in_fault),
    .buf_free   (buf_free),
    .wr_count   (wr_count),
    .wr_pc      (wr_pc),
    .wr_parcel  (wr_parcel),
    .wr_fault   (wr_fault),
    .perf_stall (perf_stall),
    .perf_parcel(perf_parcel)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Model: slice a line into the writes the stage should make with a fixed buf_free.
  task automatic push_line(input logic [31:0] pc, input logic [LW-1:0] line,
                           input logic fault, input int unsigned free);
    int unsigned off, n;
    logic [31:0] p;
    logic [15:0] lp [8];
    exp_t e;
    for (int i = 0; i < 8; i++) lp[i] = line[i*16 +: 16];
    off = 32'(pc[3:1]);
    p   = {pc[31:1], 1'b0};
    if (fault) begin
      e.cnt = 3'd1; e.pc = p; e.par = '0; e.fault = 1'b1; e.last = 1'b1;
      q.push_back(e);
    end else begin
      while (off < 8) begin
        n = 8 - off;
        if (n > 4) n = 4;
        if (n > free) n = free;
        e.cnt = 3'(n); e.pc = p; e.par = '0; e.fault = 1'b0;
        for (int unsigned k = 0; k < n; k++) e.par[k*16 +: 16] = lp[off+k];
        off = off + n;
        p   = p + 32'(2*n);
        e.last = (off == 8);
        q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (wr_count !== 3'd0) begin bad++; $display("FAIL reset_wr_count got=%0d want=0", wr_count); end
    total++; if (wr_pc !== 32'd0) begin bad++; $display("FAIL reset_wr_pc got=%h want=0", wr_pc); end
    total++; if (wr_parcel !== 64'd0 || wr_fault !== 1'b0) begin bad++; $display("FAIL reset_parcel got=%h/%b want=0/0", wr_parcel, wr_fault); end
    total++; if (perf_stall !== 32'd0 || perf_parcel !== 32'd0) begin bad++; $display("FAIL reset_perf got=%0d/%0d want=0/0", perf_stall, perf_parcel); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_lines();
    logic [31:0]   pcs   [7] = '{32'h1000, 32'h100C, 32'h2000, 32'h3004, 32'h1002, 32'h700E, 32'h5005};
    int unsigned   frees [7] = '{8, 8, 1, 8, 3, 2, 8};
    logic          faults[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [LW-1:0] line;
    exp_t e;
    for (int s = 0; s < 7; s++) begin
      line = rand_line();
      push_line(pcs[s], line, faults[s], frees[s]);
      in_valid = 1'b1; in_pc = pcs[s]; in_line = line; in_fault = faults[s];
      buf_free = FW'(frees[s]);
      @(posedge clk); #1;
      in_valid = 1'b0; in_fault = 1'b0; in_line = rand_line(); in_pc = $urandom;
      while (q.size() != 0) begin
        @(negedge clk);
        e = q.pop_front();
        total++;
        if (wr_count !== e.cnt || wr_pc !== e.pc || wr_parcel !== e.par || wr_fault !== e.fault) begin
          bad++;
          $display("FAIL line%0d_write got cnt=%0d pc=%h par=%h f=%b want cnt=%0d pc=%h par=%h f=%b",
                   s, wr_count, wr_pc, wr_parcel, wr_fault, e.cnt, e.pc, e.par, e.fault);
        end
        total++;
        if (in_ready !== e.last) begin bad++; $display("FAIL line%0d_ready got=%b want=%b", s, in_ready, e.last); end
        exp_pp = exp_pp + 32'(e.cnt);
        @(posedge clk); #1;
      end
      @(negedge clk);
      total++;
      if (wr_count !== 3'd0 || in_ready !== 1'b1) begin
        bad++; $display("FAIL line%0d_idle got cnt=%0d ready=%b want cnt=0 ready=1", s, wr_count, in_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [LW-1:0] la, lb;
    logic acc;
    exp_t e;
    la = rand_line(); lb = rand_line();
    buf_free = FW'(8);
    push_line(32'h4000, la, 1'b0, 8);
    push_line(32'h4104, lb, 1'b0, 8);
    in_valid = 1'b1; in_pc = 32'h4000; in_line = la;
    @(posedge clk); #1;
    in_pc = 32'h4104; in_line = lb;
    while (q.size() != 0) begin
      @(negedge clk);
      e = q.pop_front();
      total++;
      if (wr_count !== e.cnt || wr_pc !== e.pc || wr_parcel !== e.par || wr_fault !== e.fault) begin
        bad++;
        $display("FAIL b2b_write got cnt=%0d pc=%h par=%h f=%b want cnt=%0d pc=%h par=%h f=%b",
                 wr_count, wr_pc, wr_parcel, wr_fault, e.cnt, e.pc, e.par, e.fault);
      end
      total++;
      if (in_ready !== e.last) begin bad++; $display("FAIL b2b_ready got=%b want=%b", in_ready, e.last); end
      exp_pp = exp_pp + 32'(e.cnt);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin in_valid = 1'b0; in_line = rand_line(); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (wr_count !== 3'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_idle got cnt=%0d ready=%b want cnt=0 ready=1", wr_count, in_ready);
    end
  endtask

  task automatic test_flush();
    buf_free = FW'(8);
    in_valid = 1'b1; in_pc = 32'h1000; in_line = rand_line();
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (wr_count !== 3'd4 || wr_pc !== 32'h1000) begin
      bad++; $display("FAIL flush_first got cnt=%0d pc=%h want cnt=4 pc=00001000", wr_count, wr_pc);
    end
    exp_pp = exp_pp + 32'd4;
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h5000; in_line = rand_line();
    @(negedge clk);
    total++;
    if (wr_count !== 3'd0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL flush_cycle got cnt=%0d ready=%b want cnt=0 ready=0", wr_count, in_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (wr_count !== 3'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_idle got cnt=%0d ready=%b want cnt=0 ready=1", wr_count, in_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (wr_count !== 3'd0) begin bad++; $display("FAIL flush_dropped got cnt=%0d want=0", wr_count); end
  endtask

  task automatic test_stall_reset();
    logic [LW-1:0] line;
    line = rand_line();
    buf_free = FW'(8); stall = 1'b1;
    in_valid = 1'b1; in_pc = 32'h6000; in_line = line;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // two stalled cycles, then one cycle with no buffer space
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (wr_count !== 3'd0 || in_ready !== 1'b0) begin
        bad++; $display("FAIL hold%0d got cnt=%0d ready=%b want cnt=0 ready=0", i, wr_count, in_ready);
      end
      @(posedge clk); #1;
      if (i == 1) begin stall = 1'b0; buf_free = '0; end
      if (i == 2) buf_free = FW'(8);
    end
    @(negedge clk);
    total++;
    if (wr_count !== 3'd4 || wr_pc !== 32'h6000 || wr_parcel !== line[63:0]) begin
      bad++; $display("FAIL resume got cnt=%0d pc=%h par=%h want cnt=4 pc=00006000 par=%h", wr_count, wr_pc, wr_parcel, line[63:0]);
    end
    total++;
    if (perf_stall !== (PERF ? 32'd3 : 32'd0)) begin
      bad++; $display("FAIL perf_stall got=%0d want=%0d", perf_stall, PERF ? 3 : 0);
    end
    total++;
    if (perf_parcel !== (PERF ? exp_pp : 32'd0)) begin
      bad++; $display("FAIL perf_parcel got=%0d want=%0d", perf_parcel, PERF ? exp_pp : 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++;
    if (wr_count !== 3'd0 || wr_pc !== 32'd0 || wr_parcel !== 64'd0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL async_reset got cnt=%0d pc=%h par=%h ready=%b want all 0", wr_count, wr_pc, wr_parcel, in_ready);
    end
    total++;
    if (perf_stall !== 32'd0 || perf_parcel !== 32'd0) begin
      bad++; $display("FAIL reset_perf2 got=%0d/%0d want=0/0", perf_stall, perf_parcel);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (wr_count !== 3'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset got cnt=%0d ready=%b want cnt=0 ready=1", wr_count, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_lines();
    test_back_to_back();
    test_flush();
    test_stall_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
